// File: rtl/phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : phase_scheduler
// Description : Tick-driven two-road phase sequencer with pedestrian-request
//               truncation and night flash mode.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_scheduler #(
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int RED_T     = 2,
  parameter int MIN_GREEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             night_i,
  input  logic [1:0]       ped_req_i,
  output logic [1:0]       ped_ack_o,
  output logic [2:0]       light_a_o,
  output logic [2:0]       light_b_o,
  output logic [1:0]       walk_o,
  output logic [CNT_W-1:0] remain_o
);

  typedef enum logic [2:0] {
    ST_AR    = 3'd0,
    ST_BG    = 3'd1,
    ST_BY    = 3'd2,
    ST_BR    = 3'd3,
    ST_AG    = 3'd4,
    ST_AY    = 3'd5,
    ST_FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] C_GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] C_YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_RED_LD    = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] C_TRUNC_TH  = CNT_W'(GREEN_T - 1 - MIN_GREEN);
  localparam logic [2:0]       C_LAMP_R    = 3'b100;
  localparam logic [2:0]       C_LAMP_Y    = 3'b010;
  localparam logic [2:0]       C_LAMP_G    = 3'b001;
  localparam logic [2:0]       C_LAMP_OFF  = 3'b000;

  state_t           r_state;
  logic [CNT_W-1:0] r_remain;
  logic [1:0]       r_pend;
  logic             r_flash_ph;
  logic [1:0]       r_req_d;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_remain;
  logic             w_next_flash;
  logic [1:0]       w_next_pend;
  logic [1:0]       w_rise;
  logic [1:0]       w_rise_ok;
  logic             w_trunc;
  logic             w_enter_ag;
  logic             w_enter_bg;
  logic [1:0]       w_ack;
  logic [2:0]       w_light_a;
  logic [2:0]       w_light_b;
  logic [1:0]       w_walk;

  always_comb begin
    w_rise    = ped_req_i & ~r_req_d;
    // A press on a crossing whose walk is already showing is dropped.
    w_rise_ok = w_rise & ~{(r_state == ST_AG), (r_state == ST_BG)};
    w_trunc   = (((r_state == ST_AG) && r_pend[0]) || ((r_state == ST_BG) && r_pend[1]))
                && (r_remain <= C_TRUNC_TH);

    w_next_state  = r_state;
    w_next_remain = r_remain;
    w_next_flash  = r_flash_ph;

    if (tick_i) begin
      if (r_state == ST_FLASH) begin
        if (!night_i) begin
          w_next_state  = ST_BR;
          w_next_remain = C_RED_LD;
          w_next_flash  = 1'b0;
        end else begin
          w_next_flash  = ~r_flash_ph;
        end
      end else if ((r_remain == '0) || w_trunc) begin
        case (r_state)
          ST_AR, ST_BR: begin
            if (night_i) begin
              w_next_state  = ST_FLASH;
              w_next_remain = '0;
              w_next_flash  = 1'b1;
            end else begin
              w_next_state  = (r_state == ST_BR) ? ST_AG : ST_BG;
              w_next_remain = C_GREEN_LD;
            end
          end
          ST_AG: begin
            w_next_state  = ST_AY;
            w_next_remain = C_YELLOW_LD;
          end
          ST_AY: begin
            w_next_state  = ST_AR;
            w_next_remain = C_RED_LD;
          end
          ST_BG: begin
            w_next_state  = ST_BY;
            w_next_remain = C_YELLOW_LD;
          end
          ST_BY: begin
            w_next_state  = ST_BR;
            w_next_remain = C_RED_LD;
          end
          default: begin
            w_next_state  = ST_BR;
            w_next_remain = C_RED_LD;
          end
        endcase
      end else begin
        w_next_remain = r_remain - 1'b1;
      end
    end

    w_enter_ag = (w_next_state == ST_AG) && (r_state != ST_AG);
    w_enter_bg = (w_next_state == ST_BG) && (r_state != ST_BG);

    // Clear on green entry beats a same-cycle press; the ack covers that press.
    w_next_pend = r_pend | w_rise_ok;
    if (w_enter_bg) w_next_pend[0] = 1'b0;
    if (w_enter_ag) w_next_pend[1] = 1'b0;
    if ((r_state == ST_FLASH) || (w_next_state == ST_FLASH)) w_next_pend = 2'b00;

    w_ack = {w_enter_ag & (r_pend[1] | w_rise_ok[1]),
             w_enter_bg & (r_pend[0] | w_rise_ok[0])};

    w_light_a = C_LAMP_R;
    w_light_b = C_LAMP_R;
    case (w_next_state)
      ST_AG:    w_light_a = C_LAMP_G;
      ST_AY:    w_light_a = C_LAMP_Y;
      ST_BG:    w_light_b = C_LAMP_G;
      ST_BY:    w_light_b = C_LAMP_Y;
      ST_FLASH: begin
        w_light_a = w_next_flash ? C_LAMP_Y : C_LAMP_OFF;
        w_light_b = w_next_flash ? C_LAMP_Y : C_LAMP_OFF;
      end
      default: ;
    endcase
    w_walk = {(w_next_state == ST_AG), (w_next_state == ST_BG)};
  end

  // Outputs are registered from the next-state decode, so they settle one
  // cycle after the tick edge and never see an input combinationally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_BR;
      r_remain   <= C_RED_LD;
      r_pend     <= 2'b00;
      r_flash_ph <= 1'b0;
      r_req_d    <= 2'b00;
      light_a_o  <= C_LAMP_R;
      light_b_o  <= C_LAMP_R;
      walk_o     <= 2'b00;
      ped_ack_o  <= 2'b00;
      remain_o   <= C_RED_LD;
    end else begin
      r_state    <= w_next_state;
      r_remain   <= w_next_remain;
      r_pend     <= w_next_pend;
      r_flash_ph <= w_next_flash;
      r_req_d    <= ped_req_i;
      light_a_o  <= w_light_a;
      light_b_o  <= w_light_b;
      walk_o     <= w_walk;
      ped_ack_o  <= w_ack;
      remain_o   <= w_next_remain;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_scheduler
// Description : Self-checking bench for phase_scheduler (vector table plus
//               directed multi-cycle sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_scheduler;

  localparam logic [2:0] C_R   = 3'b100;
  localparam logic [2:0] C_Y   = 3'b010;
  localparam logic [2:0] C_G   = 3'b001;
  localparam logic [2:0] C_OFF = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       night = 1'b0;
  logic [1:0] ped_req = 2'b00;
  logic [1:0] ped_ack;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic [1:0] walk;
  logic [3:0] remain;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       tick;
    logic       night;
    logic [1:0] req;
    logic [2:0] la;
    logic [2:0] lb;
    logic [1:0] walk;
    logic [3:0] rem;
    logic [1:0] ack;
  } vec_t;

  vec_t vecs[$];

  phase_scheduler #(
    .GREEN_T  (10),
    .YELLOW_T (3),
    .RED_T    (2),
    .MIN_GREEN(4),
    .CNT_W    (4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .tick_i   (tick),
    .night_i  (night),
    .ped_req_i(ped_req),
    .ped_ack_o(ped_ack),
    .light_a_o(light_a),
    .light_b_o(light_b),
    .walk_o   (walk),
    .remain_o (remain)
  );

  always #5 clk = ~clk;

  task automatic step(input logic t, input logic n, input logic [1:0] r);
    @(negedge clk);
    tick    = t;
    night   = n;
    ped_req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int cnt, input logic n);
    for (int i = 0; i < cnt; i++) step(1'b1, n, 2'b00);
  endtask

  task automatic expect_out(input string name, input logic [2:0] la, input logic [2:0] lb,
                            input logic [1:0] w, input logic [3:0] rem, input logic [1:0] ack);
    checks++;
    if ({light_a, light_b, walk, remain, ped_ack} !== {la, lb, w, rem, ack}) begin
      errors++;
      $display("FAIL %s: got a=%b b=%b walk=%b remain=%0d ack=%b, want a=%b b=%b walk=%b remain=%0d ack=%b",
               name, light_a, light_b, walk, remain, ped_ack, la, lb, w, rem, ack);
    end
  endtask

  task automatic add_run(input logic [2:0] la, input logic [2:0] lb, input logic [1:0] w,
                         input int hi, input int lo);
    for (int r = hi; r >= lo; r--) begin
      vec_t v;
      v.tick  = 1'b1;
      v.night = 1'b0;
      v.req   = 2'b00;
      v.la    = la;
      v.lb    = lb;
      v.walk  = w;
      v.rem   = 4'(r);
      v.ack   = 2'b00;
      vecs.push_back(v);
    end
  endtask

  initial begin
    // One untruncated 30-tick cycle starting from the reset phase BR(remain=1).
    add_run(C_R, C_R, 2'b00, 0, 0);
    add_run(C_G, C_R, 2'b10, 9, 0);
    add_run(C_Y, C_R, 2'b00, 2, 0);
    add_run(C_R, C_R, 2'b00, 1, 0);
    add_run(C_R, C_G, 2'b01, 9, 0);
    add_run(C_R, C_Y, 2'b00, 2, 0);
    add_run(C_R, C_R, 2'b00, 1, 1);

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 expect_out("reset", C_R, C_R, 2'b00, 4'd1, 2'b00);
    @(negedge clk) rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].tick, vecs[i].night, vecs[i].req);
      expect_out($sformatf("free[%0d]", i), vecs[i].la, vecs[i].lb, vecs[i].walk,
                 vecs[i].rem, vecs[i].ack);
    end

    // Request for crossing A right after AG entry truncates at remain 5.
    ticks(2, 1'b0);
    expect_out("a_ag_entry", C_G, C_R, 2'b10, 4'd9, 2'b00);
    step(1'b0, 1'b0, 2'b01);
    expect_out("a_req_latched", C_G, C_R, 2'b10, 4'd9, 2'b00);
    ticks(4, 1'b0);
    expect_out("a_ag_at_thr", C_G, C_R, 2'b10, 4'd5, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    expect_out("a_trunc_ay", C_Y, C_R, 2'b00, 4'd2, 2'b00);
    ticks(4, 1'b0);
    expect_out("a_ar_end", C_R, C_R, 2'b00, 4'd0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    expect_out("a_bg_ack", C_R, C_G, 2'b01, 4'd9, 2'b01);
    step(1'b0, 1'b0, 2'b00);
    expect_out("a_ack_1cyc", C_R, C_G, 2'b01, 4'd9, 2'b00);

    // Press on the entry tick is served; press during own walk is dropped;
    // press on the threshold tick only truncates at the following tick.
    ticks(14, 1'b0);
    expect_out("b_br_end", C_R, C_R, 2'b00, 4'd0, 2'b00);
    step(1'b1, 1'b0, 2'b10);
    expect_out("b_ag_ack_same_cyc", C_G, C_R, 2'b10, 4'd9, 2'b10);
    step(1'b0, 1'b0, 2'b00);
    expect_out("b_ack_1cyc", C_G, C_R, 2'b10, 4'd9, 2'b00);
    step(1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b0, 2'b00);
    ticks(4, 1'b0);
    expect_out("b_ag_thr", C_G, C_R, 2'b10, 4'd5, 2'b00);
    step(1'b1, 1'b0, 2'b01);
    expect_out("b_no_trunc_same_tick", C_G, C_R, 2'b10, 4'd4, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    expect_out("b_trunc_next", C_Y, C_R, 2'b00, 4'd2, 2'b00);
    ticks(5, 1'b0);
    expect_out("b_bg_ack", C_R, C_G, 2'b01, 4'd9, 2'b01);
    ticks(5, 1'b0);
    expect_out("b_bg_full", C_R, C_G, 2'b01, 4'd4, 2'b00);

    // Night mode takes effect only at the end of the all-red phase.
    ticks(4, 1'b1);
    step(1'b1, 1'b1, 2'b00);
    expect_out("n_by_normal", C_R, C_Y, 2'b00, 4'd2, 2'b00);
    ticks(4, 1'b1);
    expect_out("n_br_end", C_R, C_R, 2'b00, 4'd0, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    expect_out("n_flash_on", C_Y, C_Y, 2'b00, 4'd0, 2'b00);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b00);
    expect_out("n_flash_noack", C_Y, C_Y, 2'b00, 4'd0, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    expect_out("n_flash_off", C_OFF, C_OFF, 2'b00, 4'd0, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    expect_out("n_flash_on2", C_Y, C_Y, 2'b00, 4'd0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    expect_out("n_exit_br", C_R, C_R, 2'b00, 4'd1, 2'b00);
    ticks(2, 1'b0);
    expect_out("n_ag_noack", C_G, C_R, 2'b10, 4'd9, 2'b00);

    // Asynchronous reset mid-BG with a pending request.
    ticks(15, 1'b0);
    expect_out("r_bg", C_R, C_G, 2'b01, 4'd9, 2'b00);
    step(1'b0, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b00);
    expect_out("r_bg8", C_R, C_G, 2'b01, 4'd8, 2'b00);
    @(negedge clk);
    tick = 1'b0;
    #2 rst = 1'b0;
    #1 expect_out("r_async", C_R, C_R, 2'b00, 4'd1, 2'b00);
    @(negedge clk) rst = 1'b1;
    step(1'b1, 1'b0, 2'b00);
    expect_out("r_br0", C_R, C_R, 2'b00, 4'd0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    expect_out("r_ag_noack", C_G, C_R, 2'b10, 4'd9, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phase_scheduler.md
# phase_scheduler

Tick-driven phase sequencer for the two-road intersection: it steps road A and road B through green, yellow and all-red phases. It arbitrates latched pedestrian-crossing requests by truncating the conflicting green once a minimum green has elapsed, and it switches to night flash mode on request. It sits between the clock divider's 1 Hz tick and the LED drivers, and owns all phase timing.

## Interface
- GREEN_T, 10: green phase length in ticks
- YELLOW_T, 3: yellow phase length in ticks
- RED_T, 2: all-red clearance length in ticks
- MIN_GREEN, 4: ticks a green must complete before a request may truncate it; must be < GREEN_T
- CNT_W, 4: countdown width; must hold max(GREEN_T,YELLOW_T,RED_T)-1
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- tick_i  in  1  one-cycle pulse from the clock divider, one per second
- night_i  in  1  level; 1 requests night flash mode
- ped_req_i  in  2  level buttons, synchronized upstream; [0] = cross road A, [1] = cross road B
- ped_ack_o  out  2  one-cycle pulse when the corresponding request is served
- light_a_o  out  3  road A lamps {R,Y,G}
- light_b_o  out  3  road B lamps {R,Y,G}
- walk_o  out  2  walk signal per crossing
- remain_o  out  CNT_W  ticks remaining in the current phase

## Operation
- States: AR (all-red after A), BG, BY, BR (all-red after B), AG, AY, FLASH.
- Normal cycle: BR -> AG -> AY -> AR -> BG -> BY -> BR.
- On phase entry, remain is loaded with length-1. Each tick decrements it. A tick with remain==0 moves to the next phase.
- Lamps: AG gives A=G, B=R. AY gives A=Y, B=R. BG gives A=R, B=G. BY gives A=R, B=Y. AR and BR give both R.
- walk_o[0] = 1 only in BG (road A stopped). walk_o[1] = 1 only in AG.
- Request latch pend[1:0] is set on a rising edge of ped_req_i[k].
  - A rising edge while that crossing's walk is already active is dropped.
  - pend[0] is cleared on entry to BG; pend[1] is cleared on entry to AG. ped_ack_o[k] pulses in the cycle after that entry edge.
  - If a rising edge and the clear occur in the same cycle, the clear wins and the ack covers the request.
- Truncation: in AG with pend[0]=1, or in BG with pend[1]=1, a tick with remain <= GREEN_T-1-MIN_GREEN moves immediately to the yellow phase. Green therefore lasts at least MIN_GREEN+1 ticks.
- A request arriving after the threshold is reached truncates at the next tick.
- Night mode:
  - night_i is sampled only at the tick that ends AR or BR. If it is 1, FLASH is entered instead of the next green.
  - In FLASH: both roads show Y when flash_ph=1 and all lamps off when flash_ph=0. flash_ph is set to 1 on entry and toggles each tick.
  - In FLASH: walk_o=0, remain_o=0, pend is cleared and rising edges are ignored. No acks are issued.
  - Exit: the first tick with night_i=0 enters BR with remain=RED_T-1.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.

## Timing
- Reset (rst_i=0, asynchronous): state=BR, remain=RED_T-1, pend=0, flash_ph=0, light_a_o=light_b_o=3'b100, walk_o=0, ped_ack_o=0.
- Ticks are the only events that change state or remain. Edge detection and pend run every clk_i cycle.
- State updates on the clk_i edge where tick_i=1. Outputs reflect the new phase in the following cycle.
- With defaults, a full untruncated cycle is 30 ticks.
- Reset asserted mid-phase abandons the phase immediately. Lamps go to all-red asynchronously.
- If tick_i and a rising edge of ped_req_i occur in the same cycle, the edge is latched first. The truncation check uses the pend value from before that cycle; the new request takes effect at the next tick.

## Test plan
- Reset, then 2 ticks -> AG entered, light_a_o=001, light_b_o=100, remain_o=9, walk_o=10. After 10 more ticks: AY with remain_o=2.
- Free-run 30 ticks with no requests -> exact sequence BR(2) AG(10) AY(3) AR(2) BG(10) BY(3), and walk_o[0] high only during BG.
- Pulse ped_req_i[0] right after AG entry -> AY entered at the tick where remain_o==5 (green lasted 5 ticks). At BG entry, ped_ack_o[0] is a single one-cycle pulse and pend[0] clears.
- Pulse ped_req_i[1] while walk_o[1]=1 in AG -> no latch, no ack, and the following BG runs the full 10 ticks.
- Hold night_i=1 during AG -> no change until the end of AR, then FLASH: both lamps alternate 010/000 each tick and requests are ignored. Drop night_i -> BR, then AG after 2 ticks.
- Assert rst_i=0 mid-BG with pend=01 -> lamps immediately 100/100, pend cleared. After release, the sequence restarts from BR.
